// File: rtl/systolic_array_sched.sv
// Sequencer for an output-stationary DIMENSION x DIMENSION systolic array: it feeds skewed
// operand streams into the grid, waits for the grid to finish, then drains the accumulators row-major.
module systolic_array_sched #(
  parameter int DIMENSION  = 4,
  parameter int I_BITS     = 8,
  parameter int O_BITS     = 2*I_BITS + $clog2(DIMENSION),
  parameter int ADDR_BITS  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1,
  parameter int WAIT_LIMIT = 2*DIMENSION
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_start,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic                                 o_rd_en,
  output logic [ADDR_BITS-1:0]                 o_rd_addr,
  input  logic [DIMENSION*I_BITS-1:0]          i_a_col,
  input  logic [DIMENSION*I_BITS-1:0]          i_b_row,
  output logic                                 o_array_clear,
  output logic [DIMENSION*I_BITS-1:0]          o_west_a,
  output logic [DIMENSION*I_BITS-1:0]          o_north_b,
  input  logic                                 i_array_finish,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_array_c,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [O_BITS-1:0]                    o_res_data,
  output logic [2*ADDR_BITS-1:0]               o_res_idx
);

  localparam int F_BITS   = $clog2(2*DIMENSION);
  localparam int F_LAST   = 2*DIMENSION - 2;
  localparam int W_BITS   = $clog2(WAIT_LIMIT + 1);
  localparam int CELLS    = DIMENSION*DIMENSION;
  localparam int SEL_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                   state_q;
  logic [F_BITS-1:0]        feed_q;
  logic [W_BITS-1:0]        wait_q;
  logic [ADDR_BITS-1:0]     row_q;
  logic [ADDR_BITS-1:0]     col_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;
  logic                     rd_en_q;
  logic [ADDR_BITS-1:0]     rd_addr_q;
  logic                     clear_q;
  logic                     res_valid_q;
  logic                     rd_valid_q;

  logic [F_BITS:0]          rd_next_d;
  logic [DIMENSION*I_BITS-1:0] a_gated_d;
  logic [DIMENSION*I_BITS-1:0] b_gated_d;
  logic [SEL_BITS-1:0]      res_sel_d;
  logic [O_BITS-1:0]        acc_w [CELLS];

  // Operand index the read issued during the next FEED cycle will fetch.
  assign rd_next_d = {1'b0, feed_q} + (F_BITS+1)'(2);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      feed_q      <= '0;
      wait_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      clear_q     <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            clear_q   <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q   <= S_FEED;
          feed_q    <= '0;
          clear_q   <= 1'b0;
          rd_en_q   <= (DIMENSION > 1);
          rd_addr_q <= ADDR_BITS'(1);
        end
        S_FEED: begin
          if (feed_q == F_BITS'(F_LAST)) begin
            state_q   <= S_WAIT;
            wait_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            feed_q <= feed_q + F_BITS'(1);
            if (rd_next_d < (F_BITS+1)'(DIMENSION)) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_next_d[ADDR_BITS-1:0];
            end else begin
              rd_en_q   <= 1'b0;
              rd_addr_q <= '0;
            end
          end
        end
        S_WAIT: begin
          if (i_array_finish) begin
            state_q     <= S_DRAIN;
            res_valid_q <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
          end else if (wait_q == W_BITS'(WAIT_LIMIT - 1)) begin
            // Grid never finished: abandon the run without a done pulse.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            clear_q <= 1'b1;
          end else begin
            wait_q <= wait_q + W_BITS'(1);
          end
        end
        S_DRAIN: begin
          if (res_valid_q && i_res_ready) begin
            if (col_q == ADDR_BITS'(DIMENSION - 1)) begin
              col_q <= '0;
              if (row_q == ADDR_BITS'(DIMENSION - 1)) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                res_valid_q <= 1'b0;
                done_q      <= 1'b1;
                clear_q     <= 1'b1;
                row_q       <= '0;
              end else begin
                row_q <= row_q + ADDR_BITS'(1);
              end
            end else begin
              col_q <= col_q + ADDR_BITS'(1);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          rd_en_q     <= 1'b0;
          clear_q     <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer data is only meaningful the cycle after a read; otherwise it is stale.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_q;
    end
  end

  assign a_gated_d = rd_valid_q ? i_a_col : '0;
  assign b_gated_d = rd_valid_q ? i_b_row : '0;

  generate
    for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
        assign o_west_a[0 +: I_BITS]  = a_gated_d[0 +: I_BITS];
        assign o_north_b[0 +: I_BITS] = b_gated_d[0 +: I_BITS];
      end else begin : g_delay
        // Lane gi lags lane 0 by gi cycles so operand k meets PE(i,j) at cycle k+i+j.
        logic [I_BITS-1:0] a_dly_q [gi];
        logic [I_BITS-1:0] b_dly_q [gi];

        always_ff @(posedge i_clock) begin
          if (i_reset) begin
            for (int s = 0; s < gi; s++) begin
              a_dly_q[s] <= '0;
              b_dly_q[s] <= '0;
            end
          end else begin
            a_dly_q[0] <= a_gated_d[gi*I_BITS +: I_BITS];
            b_dly_q[0] <= b_gated_d[gi*I_BITS +: I_BITS];
            for (int s = 1; s < gi; s++) begin
              a_dly_q[s] <= a_dly_q[s-1];
              b_dly_q[s] <= b_dly_q[s-1];
            end
          end
        end

        assign o_west_a[gi*I_BITS +: I_BITS]  = a_dly_q[gi-1];
        assign o_north_b[gi*I_BITS +: I_BITS] = b_dly_q[gi-1];
      end
    end

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_acc
      assign acc_w[gi] = i_array_c[gi*O_BITS +: O_BITS];
    end
  endgenerate

  assign res_sel_d = SEL_BITS'(int'(row_q) * DIMENSION + int'(col_q));

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_rd_en       = rd_en_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_array_clear = clear_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_idx     = {row_q, col_q};
  // Accumulators are frozen during DRAIN, so a direct select stays stable under backpressure.
  assign o_res_data    = res_valid_q ? acc_w[res_sel_d] : '0;

endmodule

// File: tb/tb_systolic_array_sched.sv
// Bench for systolic_array_sched: operand buffers and a counter-gated PE grid around the DUT,
// a timeline/scoreboard model checked every cycle, plus directed literal checks.
module tb_systolic_array_sched;
  localparam int D  = 4;
  localparam int IB = 8;
  localparam int OB = 2*IB + $clog2(D);
  localparam int AB = 2;
  localparam int WL = 2*D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                start;
  logic                o_busy, o_done, o_error, o_rd_en;
  logic [AB-1:0]       o_rd_addr;
  logic [D*IB-1:0]     a_col, b_row;
  logic                o_array_clear;
  logic [D*IB-1:0]     o_west_a, o_north_b;
  logic                finish;
  logic [D*D*OB-1:0]   arr_c;
  logic                o_res_valid;
  logic                ready;
  logic [OB-1:0]       o_res_data;
  logic [2*AB-1:0]     o_res_idx;

  systolic_array_sched #(.DIMENSION(D), .I_BITS(IB)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_a_col(a_col), .i_b_row(b_row),
    .o_array_clear(o_array_clear), .o_west_a(o_west_a), .o_north_b(o_north_b),
    .i_array_finish(finish), .i_array_c(arr_c),
    .o_res_valid(o_res_valid), .i_res_ready(ready),
    .o_res_data(o_res_data), .o_res_idx(o_res_idx)
  );

  logic signed [IB-1:0] ma [D][D];
  logic signed [IB-1:0] mb [D][D];
  logic [OB-1:0]        cexp [D*D];
  logic [OB-1:0]        got  [D*D];
  int  total = 0;
  int  bad = 0;
  int  done_seen = 0;
  bit  nofin = 1'b0;

  // Timeline model: tt counts cycles since the accepted start (1 = CLEAR, 2.. = FEED f=tt-2).
  bit  exp_idle = 1'b1;
  bit  exp_err = 1'b0;
  bit  exp_done = 1'b0;
  bit  in_drain = 1'b0;
  int  tt = 0;
  int  q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void calc_c();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < D; k++) s += int'(ma[i][k]) * int'(mb[k][j]) * 8;
        cexp[i*D+j] = OB'(s);
      end
  endfunction

  // Compare and advance the model once per cycle.
  initial begin
    forever begin
      logic [D*IB-1:0] ew, en;
      bit act;
      int f;
      @(negedge clk);
      act = !exp_idle;
      chk("busy", 64'(o_busy), 64'(act));
      chk("done", 64'(o_done), 64'(exp_done));
      chk("error", 64'(o_error), 64'(exp_err));
      chk("clear", 64'(o_array_clear), 64'(!act || tt == 1));
      chk("rd_en", 64'(o_rd_en), 64'(act && tt >= 1 && tt <= D && !in_drain));
      if (act && tt >= 1 && tt <= D) chk("rd_addr", 64'(o_rd_addr), 64'(tt - 1));
      ew = '0;
      en = '0;
      if (act && tt >= 2 && tt <= 2*D) begin
        f = tt - 2;
        for (int i = 0; i < D; i++)
          if (f - i >= 0 && f - i < D) begin
            ew[i*IB +: IB] = ma[i][f-i];
            en[i*IB +: IB] = mb[f-i][i];
          end
      end
      chk("west", 64'(o_west_a), 64'(ew));
      chk("north", 64'(o_north_b), 64'(en));
      chk("res_valid", 64'(o_res_valid), 64'(in_drain));
      if (in_drain && q.size() > 0) begin
        chk("res_idx", 64'(o_res_idx), 64'((q[0] / D) * 4 + q[0] % D));
        chk("res_data", 64'(o_res_data), 64'(cexp[q[0]]));
        if (o_res_valid && ready) got[q[0]] = o_res_data;
      end
      if (o_done) done_seen++;

      if (rst) begin
        exp_idle = 1'b1; exp_err = 1'b0; exp_done = 1'b0; in_drain = 1'b0; tt = 0;
        q.delete();
      end else begin
        exp_done = 1'b0;
        if (exp_idle) begin
          if (start) begin
            exp_idle = 1'b0; exp_err = 1'b0; tt = 1; in_drain = 1'b0;
            q.delete();
            for (int n = 0; n < D*D; n++) q.push_back(n);
          end
        end else if (in_drain) begin
          if (ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
              in_drain = 1'b0; exp_idle = 1'b1; exp_done = 1'b1;
            end
          end
        end else begin
          if (tt > 2*D && finish) in_drain = 1'b1;
          else if (tt == 2*D + WL) begin
            exp_idle = 1'b1; exp_err = 1'b1;
          end
          tt++;
        end
      end
    end
  end

  // Environment: operand buffers (registered read) and a counter-gated PE grid.
  logic signed [IB-1:0] pa [D][D];
  logic signed [IB-1:0] pb [D][D];
  int acc [D][D];
  int pcnt = 0;

  initial begin
    a_col = '0; b_row = '0; arr_c = '0; finish = 1'b0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = 0;
      end
    forever begin
      logic s_rd, s_clr;
      logic [AB-1:0] s_addr;
      logic [D*IB-1:0] s_w, s_n;
      logic signed [IB-1:0] ain, bin;
      @(negedge clk);
      s_rd = o_rd_en; s_addr = o_rd_addr; s_w = o_west_a; s_n = o_north_b; s_clr = o_array_clear;
      @(posedge clk);
      #1;
      if (s_rd === 1'b1) begin
        for (int i = 0; i < D; i++) begin
          a_col[i*IB +: IB] = ma[i][int'(s_addr)];
          b_row[i*IB +: IB] = mb[int'(s_addr)][i];
        end
      end
      if (s_clr !== 1'b0) begin
        pcnt = 0;
        for (int i = 0; i < D; i++)
          for (int j = 0; j < D; j++) begin
            pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = 0;
          end
      end else begin
        for (int i = D-1; i >= 0; i--)
          for (int j = D-1; j >= 0; j--) begin
            if (j == 0) ain = s_w[i*IB +: IB];
            else ain = pa[i][j-1];
            if (i == 0) bin = s_n[j*IB +: IB];
            else bin = pb[i-1][j];
            // Product aligned so that 1.0 * 1.0 lands at 18'h08000.
            if (pcnt < D + i + j) acc[i][j] += int'(ain) * int'(bin) * 8;
            pa[i][j] = ain;
            pb[i][j] = bin;
          end
        if (pcnt < 1000) pcnt++;
      end
      finish = !nofin && (pcnt >= 3*D - 2);
      for (int i = 0; i < D; i++)
        for (int j = 0; j < D; j++) arr_c[(i*D+j)*OB +: OB] = OB'(acc[i][j]);
    end
  end

  task automatic start_pulse();
    for (int n = 0; n < D*D; n++) got[n] = '1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int d0;
    bit seen;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    for (int i = 0; i < D; i++)
      for (int k = 0; k < D; k++) begin
        ma[i][k] = '0; mb[i][k] = '0;
      end
    calc_c();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_clear", 64'(o_array_clear), 64'(1));
    chk("rst_valid", 64'(o_res_valid), 64'(0));
    chk("rst_west", 64'(o_west_a), 64'(0));

    // Identity x identity
    for (int i = 0; i < D; i++)
      for (int k = 0; k < D; k++) begin
        ma[i][k] = (i == k) ? 8'sh40 : 8'sh00;
        mb[i][k] = (i == k) ? 8'sh40 : 8'sh00;
      end
    calc_c();
    d0 = done_seen;
    start_pulse();
    wait_idle("t1_run");
    chk("t1_c00", 64'(got[0]), 64'(18'h08000));
    chk("t1_c01", 64'(got[1]), 64'(0));
    chk("t1_c32", 64'(got[14]), 64'(0));
    chk("t1_c33", 64'(got[15]), 64'(18'h08000));
    chk("t1_done", 64'(done_seen - d0), 64'(1));

    // Skew trace
    for (int i = 0; i < D; i++)
      for (int k = 0; k < D; k++) begin
        ma[i][k] = IB'(16*i + k);
        mb[i][k] = IB'(i + 2*k + 1);
      end
    calc_c();
    start_pulse();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t2_lane2", 64'(o_west_a[23:16]), 64'(8'h23));
    chk("t2_lane3", 64'(o_west_a[31:24]), 64'(8'h32));
    chk("t2_lane0", 64'(o_west_a[7:0]), 64'(0));
    wait_idle("t2_run");

    // Ready backpressure, signed operands
    for (int i = 0; i < D; i++)
      for (int k = 0; k < D; k++) begin
        ma[i][k] = 8'sh10;
        mb[i][k] = IB'(-(k + 1));
      end
    calc_c();
    d0 = done_seen;
    ready = 1'b0;
    start_pulse();
    for (int c = 0; c < 300 && o_busy; c++) begin
      @(posedge clk); #1 ready = ~ready;
    end
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle", 64'(o_busy), 64'(0));
    chk("t3_c00", 64'(got[0]), 64'(18'h3FE00));
    chk("t3_c23", 64'(got[11]), 64'(18'h3F800));
    chk("t3_done", 64'(done_seen - d0), 64'(1));

    // Timeout
    nofin = 1'b1;
    d0 = done_seen;
    start_pulse();
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t4_err_before", 64'(o_error), 64'(0));
    chk("t4_busy_before", 64'(o_busy), 64'(1));
    @(negedge clk);
    chk("t4_err", 64'(o_error), 64'(1));
    chk("t4_idle", 64'(o_busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("t4_no_done", 64'(done_seen - d0), 64'(0));
    nofin = 1'b0;
    start_pulse();
    @(negedge clk);
    chk("t4_err_clr", 64'(o_error), 64'(0));
    wait_idle("t4_rerun");

    // Reset mid-FEED at f=3
    d0 = done_seen;
    start_pulse();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_clear", 64'(o_array_clear), 64'(1));
    chk("t5_west", 64'(o_west_a), 64'(0));
    chk("t5_north", 64'(o_north_b), 64'(0));
    chk("t5_busy", 64'(o_busy), 64'(0));
    chk("t5_rd_en", 64'(o_rd_en), 64'(0));
    start_pulse();
    wait_idle("t5_rerun");
    chk("t5_done", 64'(done_seen - d0), 64'(1));

    // Start while busy (WAIT and DRAIN), then back-to-back start in the done cycle
    d0 = done_seen;
    start_pulse();
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_drain", 64'(seen), 64'(1));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("t6_run");
    chk("t6_one_done", 64'(done_seen - d0), 64'(1));

    d0 = done_seen;
    start_pulse();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (o_done) begin
        seen = 1'b1;
        start = 1'b1;
        break;
      end
    end
    chk("t7_done_seen", 64'(seen), 64'(1));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t7_b2b_busy", 64'(o_busy), 64'(1));
    wait_idle("t7_run");
    chk("t7_two_done", 64'(done_seen - d0), 64'(2));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_array_sched.md
Name: systolic_array_sched

Overview:
- Sequencer for a DIMENSION x DIMENSION output-stationary systolic array of counter-gated MAC PEs.
- Fetches operand vectors from two single-port operand buffers and drives skewed, zero-padded streams into the array's west (A) and north (B) edges.
- Clears the array, waits for the all-PE finish flag, then drains the DIMENSION^2 accumulators row-major over a valid/ready port.
- Sits between the operand buffers/host and the PE grid.

Parameters:
- DIMENSION, 4, array side length; the grid is DIMENSION x DIMENSION PEs; PE(i,j) carries counter limit i+j.
- I_BITS, 8, operand width in S(I_BITS, I_BITS-2).
- O_BITS, 2*I_BITS+$clog2(DIMENSION), accumulator width.
- ADDR_BITS, max(1, $clog2(DIMENSION)), operand buffer address width.
- WAIT_LIMIT, 2*DIMENSION, maximum number of WAIT cycles before an error is raised.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; accepted only in IDLE.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle pulse after the last result handshake.
- o_error  out  1  sticky WAIT timeout flag; cleared by the next accepted start.
- o_rd_en  out  1  operand buffer read enable.
- o_rd_addr  out  ADDR_BITS  operand index k.
- i_a_col  in  DIMENSION*I_BITS  column k of A; slice i = A[i][k]; valid 1 cycle after o_rd_en.
- i_b_row  in  DIMENSION*I_BITS  row k of B; slice j = B[k][j]; valid 1 cycle after o_rd_en.
- o_array_clear  out  1  drives the i_reset input of every PE.
- o_west_a  out  DIMENSION*I_BITS  lane i drives the i_a input of PE(i,0).
- o_north_b  out  DIMENSION*I_BITS  lane j drives the i_b input of PE(0,j).
- i_array_finish  in  1  AND of all PE o_finish outputs.
- i_array_c  in  DIMENSION*DIMENSION*O_BITS  flat accumulators; slice i*DIMENSION+j = PE(i,j).
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result ready.
- o_res_data  out  O_BITS  C[i][j].
- o_res_idx  out  2*ADDR_BITS  {i,j}.

Behaviour:
- Reset values: state IDLE, o_busy=0, o_done=0, o_error=0, o_rd_en=0, o_rd_addr=0, o_array_clear=1, o_west_a=0, o_north_b=0, o_res_valid=0, all skew registers cleared.
- i_reset has priority in every state. An in-flight operation is abandoned and no o_done pulse is issued.

State machine: IDLE -> CLEAR -> FEED -> WAIT -> DRAIN -> IDLE.
- IDLE:
  - o_array_clear=1.
  - i_start moves to CLEAR and clears o_error.
  - i_start in any other state is ignored.
- CLEAR (1 cycle):
  - o_array_clear=1.
  - Prefetch: o_rd_en=1, o_rd_addr=0.
- FEED (2*DIMENSION-1 cycles, feed counter f=0..2*DIMENSION-2):
  - o_array_clear=0.
  - o_rd_en=1 and o_rd_addr=f+1 while f+1<DIMENSION; otherwise o_rd_en=0.
  - Buffer data is zero-gated when no read was issued in the previous cycle.
- Skew:
  - West lane i presents A[i][k] exactly at f=k+i; north lane j presents B[k][j] exactly at f=k+j.
  - Implemented with per-lane register delay lines of depth i (lane 0 has none, so it is combinational from the gated buffer data).
  - Every lane outputs 0 at all other FEED cycles and in all other states.
  - Timing check: PE(i,j) receives pair k at cycle k+i+j after clear release, which is before its accumulation stop at DIMENSION+i+j. No extra latency is permitted.
- WAIT:
  - Edges are held at 0.
  - Exit to DRAIN on i_array_finish=1.
  - After WAIT_LIMIT WAIT cycles without finish: set o_error=1, go to IDLE, and issue no o_done pulse.
  - With correct PE wiring, finish arrives at 3*DIMENSION-2 cycles after clear release, which falls within the WAIT window.
- DRAIN:
  - Index n=0..DIMENSION^2-1.
  - o_res_valid=1, o_res_data = slice n, o_res_idx = {n/DIMENSION, n%DIMENSION}.
  - n advances only on valid&&ready.
  - valid, data and idx stay stable while ready=0.
  - o_array_clear stays 0 so the accumulators are held.
  - After the handshake at n=DIMENSION^2-1: go to IDLE with o_valid=0 and pulse o_done in the following cycle.
  - A back-to-back start in the o_done cycle is accepted.
- Widths: no arithmetic on the data path. The feed counter needs $clog2(2*DIMENSION) bits; the drain index needs 2*ADDR_BITS bits.

Test Plan:
1. Identity x identity (DIMENSION=4, I_BITS=8):
   - Stimulus: A=B=I with diagonal 8'h40, start pulse, ready held at 1.
   - Required: 16 results with C[i][i]=18'h08000 and all others 0; o_done arrives one cycle after idx {3,3}.
2. Skew trace:
   - Stimulus: A[i][k]=8'h10*i+k.
   - Required: at FEED f=5, lane 2 = 8'h23 and lane 3 = 8'h32; lane 0 = 0 for f>=4.
3. Ready backpressure:
   - Stimulus: ready toggled 0/1 every cycle.
   - Required: each {i,j} appears exactly once in row-major order, with data stable while ready=0.
4. Timeout:
   - Stimulus: i_array_finish tied to 0.
   - Required: o_error=1 exactly 8 cycles after WAIT entry, state returns to IDLE, no o_done; the next start clears o_error.
5. Reset mid-FEED:
   - Stimulus: assert i_reset at f=3.
   - Required: on the next cycle all outputs are at reset values, and a subsequent run produces correct results.
6. Start while busy:
   - Stimulus: i_start during WAIT and DRAIN.
   - Required: the start is ignored, and exactly one o_done is issued per accepted start.
